// File: rtl/vidcap_pkg.sv
// Shared types and constants for the vidcapture LCD-stream capture block.
package vidcap_pkg;

    typedef enum logic [1:0] {
        S_SYNC,
        S_VBL,
        S_ACT,
        S_HBL
    } state_t;

    localparam logic [1:0] MODE_TRUNC    = 2'd0;
    localparam logic [1:0] MODE_ROUND    = 2'd1;
    localparam logic [1:0] MODE_SPATIAL  = 2'd2;
    localparam logic [1:0] MODE_TEMPORAL = 2'd3;

    localparam int DITHER_W = 2;

endpackage

// File: rtl/vidcapture_if.sv
// Pixel-stream input and VRAM write port of vidcapture; slave is the capture block.
interface vidcapture_if #(
    parameter int IN_BITS  = 4,
    parameter int OUT_BITS = 2,
    parameter int X_BITS   = 8,
    parameter int Y_BITS   = 8
);
    logic                       rgb_de;
    logic                       rgb_vsync;
    logic [IN_BITS-1:0]         rgb_data;
    logic                       vramclk;
    logic [Y_BITS+X_BITS-1:0]   vramaddr;
    logic [OUT_BITS-1:0]        vramdata;
    logic                       vramwe;

    modport master (
        output rgb_de, rgb_vsync, rgb_data,
        input  vramclk, vramaddr, vramdata, vramwe
    );

    modport slave (
        input  rgb_de, rgb_vsync, rgb_data,
        output vramclk, vramaddr, vramdata, vramwe
    );
endinterface

// File: rtl/vidcap_quant.sv
// Combinational IN_BITS -> OUT_BITS quantiser: truncate, round, or ordered dither
// with the threshold taken from (x + y + f) mod 4, then saturating add.
module vidcap_quant
    import vidcap_pkg::*;
#(
    parameter int IN_BITS  = 4,
    parameter int OUT_BITS = 2
) (
    input  logic [IN_BITS-1:0]  data,
    input  logic [1:0]          x_lo,
    input  logic [1:0]          y_lo,
    input  logic [1:0]          f,
    input  logic [1:0]          mode,
    output logic [OUT_BITS-1:0] q
);
    localparam int S = IN_BITS - OUT_BITS;

    logic [DITHER_W-1:0] d;
    logic [IN_BITS:0]    off;
    logic [IN_BITS:0]    sum;
    logic [IN_BITS-1:0]  sat;

    always_comb begin
        d = x_lo + y_lo + ((mode == MODE_TEMPORAL) ? f : 2'd0);
        unique case (mode)
            MODE_TRUNC: off = '0;
            MODE_ROUND: off = (IN_BITS+1)'(1) << (S - 1);
            default:    off = (IN_BITS+1)'(d) << (S - DITHER_W);
        endcase
        sum = {1'b0, data} + off;
        sat = sum[IN_BITS] ? {IN_BITS{1'b1}} : sum[IN_BITS-1:0];
        q   = OUT_BITS'(sat >> S);
    end
endmodule

// File: rtl/vidcapture.sv
// LCD-stream capture: frame/line FSM, x/y tracking, quantiser and registered VRAM write port.
// Define VIDCAP_TEMPORAL_EN to build the frame counter used by spatio-temporal dither (mode 3).
module vidcapture
    import vidcap_pkg::*;
#(
    parameter int IN_BITS  = 4,
    parameter int OUT_BITS = 2,
    parameter int X_BITS   = 8,
    parameter int Y_BITS   = 8,
    parameter int MAX_X    = 160,
    parameter int MAX_Y    = 144
) (
    input  logic         rgb_clk,
    input  logic         rst,
    vidcapture_if.slave  bus,
    input  logic [1:0]   mode,
    input  logic         err_clr,
    output logic         frame_done,
    output logic         x_ovf,
    output logic         y_ovf
);
    localparam logic [X_BITS:0] X_LIM = (X_BITS+1)'(MAX_X);
    localparam logic [Y_BITS:0] Y_LIM = (Y_BITS+1)'(MAX_Y);

    state_t                   state;
    logic [X_BITS:0]          x;
    logic [Y_BITS:0]          y;
    logic [1:0]               f;
    logic                     cap;
    logic                     frame_end;
    logic                     x_in;
    logic                     y_in;
    logic                     wr;
    logic [OUT_BITS-1:0]      qdata;
    logic                     vld_p1;
    logic [Y_BITS+X_BITS-1:0] addr_p1;
    logic [OUT_BITS-1:0]      data_p1;
    logic                     done_p1;

    // Counters are one bit wider than the address so they can sit at MAX_X / MAX_Y.
    assign x_in = (x < X_LIM);
    assign y_in = (y < Y_LIM);
    assign wr   = cap && x_in && y_in;

    always_comb begin
        cap       = 1'b0;
        frame_end = 1'b0;
        unique case (state)
            S_VBL, S_ACT: cap = bus.rgb_de;
            S_HBL: begin
                frame_end = bus.rgb_vsync && (y != '0);
                cap       = bus.rgb_de && !frame_end;
            end
            default: ;
        endcase
    end

`ifdef VIDCAP_TEMPORAL_EN
    logic [1:0] fc;

    always_ff @(posedge rgb_clk) begin
        if (rst)
            fc <= 2'd0;
        else if (frame_end)
            fc <= fc + 2'd1;
    end

    assign f = fc;
`else
    assign f = 2'd0;
`endif

    vidcap_quant #(
        .IN_BITS  (IN_BITS),
        .OUT_BITS (OUT_BITS)
    ) u_quant (
        .data (bus.rgb_data),
        .x_lo (x[1:0]),
        .y_lo (y[1:0]),
        .f    (f),
        .mode (mode),
        .q    (qdata)
    );

    // Stage p0 -> p1: FSM/counters advance, accepted pixel lands in the write register.
    always_ff @(posedge rgb_clk) begin
        if (rst) begin
            state   <= S_SYNC;
            x       <= '0;
            y       <= '0;
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
            done_p1 <= 1'b0;
            x_ovf   <= 1'b0;
            y_ovf   <= 1'b0;
        end else begin
            vld_p1  <= wr;
            done_p1 <= frame_end;
            if (wr) begin
                addr_p1 <= {y[Y_BITS-1:0], x[X_BITS-1:0]};
                data_p1 <= qdata;
            end
            if (cap && x_in)
                x <= x + (X_BITS+1)'(1);
            // A new overflow outranks a simultaneous clear.
            x_ovf <= (cap && !x_in) || (x_ovf && !err_clr);
            y_ovf <= (cap && !y_in) || (y_ovf && !err_clr);

            unique case (state)
                S_SYNC: if (bus.rgb_vsync) begin
                    state <= S_VBL;
                    x     <= '0;
                    y     <= '0;
                end
                S_VBL: if (bus.rgb_de)
                    state <= S_ACT;
                S_ACT: if (!bus.rgb_de) begin
                    state <= S_HBL;
                    x     <= '0;
                    if (y_in)
                        y <= y + (Y_BITS+1)'(1);
                end
                S_HBL: begin
                    if (frame_end) begin
                        state <= S_VBL;
                        x     <= '0;
                        y     <= '0;
                    end else if (bus.rgb_de) begin
                        state <= S_ACT;
                    end
                end
                default: state <= S_SYNC;
            endcase
        end
    end

    assign bus.vramclk  = rgb_clk;
    assign bus.vramaddr = addr_p1;
    assign bus.vramdata = data_p1;
    assign bus.vramwe   = vld_p1;
    assign frame_done   = done_p1;
endmodule

// File: tb/tb_vidcapture.sv
// Self-checking bench for vidcapture: randomized stream against a line/pixel-counting model.
// Mode-3 expectations follow VIDCAP_TEMPORAL_EN.
module tb_vidcapture;
    localparam int IN_BITS  = 4;
    localparam int OUT_BITS = 2;
    localparam int X_BITS   = 8;
    localparam int Y_BITS   = 8;
    localparam int MAX_X    = 160;
    localparam int MAX_Y    = 144;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'd0;
    logic       err_clr = 1'b0;
    logic       frame_done;
    logic       x_ovf;
    logic       y_ovf;

    vidcapture_if #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .X_BITS(X_BITS), .Y_BITS(Y_BITS)) vif ();

    vidcapture #(
        .IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .X_BITS(X_BITS), .Y_BITS(Y_BITS),
        .MAX_X(MAX_X), .MAX_Y(MAX_Y)
    ) dut (
        .rgb_clk    (clk),
        .rst        (rst),
        .bus        (vif),
        .mode       (mode),
        .err_clr    (err_clr),
        .frame_done (frame_done),
        .x_ovf      (x_ovf),
        .y_ovf      (y_ovf)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int last_addr = 0;

    // Model: armed after a vsync; lines counted since frame start, pixels within the line.
    bit armed = 0;
    bit in_line = 0;
    int line = 0;
    int pix = 0;
    int frames = 0;
    int e_we = 0, e_addr = 0, e_data = 0, e_done = 0, e_xo = 0, e_yo = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int quant(input int d, input int x, input int y, input int fr, input int m);
        int s, dd, off, sum, f;
        s = IN_BITS - OUT_BITS;
`ifdef VIDCAP_TEMPORAL_EN
        f = (m == 3) ? fr : 0;
`else
        f = 0;
`endif
        dd = (x + y + f) % 4;
        if (m == 0) off = 0;
        else if (m == 1) off = 1 << (s - 1);
        else off = dd << (s - 2);
        sum = d + off;
        if (sum > (1 << IN_BITS) - 1) sum = (1 << IN_BITS) - 1;
        return sum >> s;
    endfunction

    task automatic model_step();
        bit cap = 0;
        bit xs = 0;
        bit ys = 0;
        if (rst) begin
            armed = 0; in_line = 0; line = 0; pix = 0; frames = 0;
            e_we = 0; e_addr = 0; e_data = 0; e_done = 0; e_xo = 0; e_yo = 0;
        end else begin
            e_we = 0;
            e_done = 0;
            if (!armed) begin
                if (vif.rgb_vsync) begin armed = 1; line = 0; pix = 0; in_line = 0; end
            end else if (in_line) begin
                if (vif.rgb_de) cap = 1;
                else begin
                    in_line = 0;
                    pix = 0;
                    if (line < MAX_Y) line++;
                end
            end else if (vif.rgb_vsync && line != 0) begin
                e_done = 1;
                frames = (frames + 1) % 4;
                line = 0;
                pix = 0;
            end else if (vif.rgb_de) begin
                in_line = 1;
                cap = 1;
            end
            if (cap) begin
                xs = (pix >= MAX_X);
                ys = (line >= MAX_Y);
                if (!xs && !ys) begin
                    e_we = 1;
                    e_addr = line * (1 << X_BITS) + pix;
                    e_data = quant(int'(vif.rgb_data), pix, line, frames, int'(mode));
                end
                if (!xs) pix++;
            end
            if (xs) e_xo = 1; else if (err_clr) e_xo = 0;
            if (ys) e_yo = 1; else if (err_clr) e_yo = 0;
        end
    endtask

    initial forever begin
        @(negedge clk);
        model_step();
        chk("vramwe", int'(vif.vramwe), e_we);
        chk("vramaddr", int'(vif.vramaddr), e_addr);
        chk("vramdata", int'(vif.vramdata), e_data);
        chk("frame_done", int'(frame_done), e_done);
        chk("x_ovf", int'(x_ovf), e_xo);
        chk("y_ovf", int'(y_ovf), e_yo);
        if (vif.vramwe) begin wr_cnt++; last_addr = int'(vif.vramaddr); end
        if (frame_done) done_cnt++;
    end

    task automatic step(input logic de, input logic vs, input logic [IN_BITS-1:0] d);
        vif.rgb_de = de;
        vif.rgb_vsync = vs;
        vif.rgb_data = d;
        @(negedge clk);
        #1;
    endtask

    task automatic line_px(input int n, input int gap, input bit rmode);
        for (int i = 0; i < n; i++) begin
            if (rmode) mode = 2'($urandom);
            step(1'b1, 1'b0, IN_BITS'($urandom));
        end
        for (int i = 0; i < gap; i++) step(1'b0, 1'b0, '0);
    endtask

    initial begin
        vif.rgb_de = 1'b0;
        vif.rgb_vsync = 1'b0;
        vif.rgb_data = '0;
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        chk("reset_we", int'(vif.vramwe), 0);
        chk("reset_addr", int'(vif.vramaddr), 0);
        rst = 1'b0;

        // de activity before any vsync must never write
        line_px(5, 3, 1'b0);
        line_px(4, 2, 1'b0);
        chk("startup_writes", wr_cnt, 0);

        // frame A: literal quantiser points
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);
        mode = 2'd0;
        step(1'b1, 1'b0, 4'hB);
        chk("first_we", int'(vif.vramwe), 1);
        chk("first_addr", int'(vif.vramaddr), 0);
        chk("trunc_B", int'(vif.vramdata), 2);
        mode = 2'd1;
        step(1'b1, 1'b0, 4'hB);
        chk("round_B", int'(vif.vramdata), 3);
        step(1'b1, 1'b0, 4'hF);
        chk("round_F_sat", int'(vif.vramdata), 3);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        line_px(3, 2, 1'b0);
        mode = 2'd2;
        step(1'b1, 1'b0, IN_BITS'($urandom));
        step(1'b1, 1'b0, 4'h5);
        chk("spatial_addr", int'(vif.vramaddr), 16'h0201);
        chk("spatial_x1y2", int'(vif.vramdata), 2);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 4'h5);
        chk("vsync_de_drop", int'(vif.vramwe), 0);
        chk("frame_done_pulse", int'(frame_done), 1);
        step(1'b0, 1'b0, '0);
        chk("frame_done_single", int'(frame_done), 0);

        // frame B: same pixel in mode 3
        line_px(2, 2, 1'b0);
        line_px(2, 2, 1'b0);
        mode = 2'd3;
        step(1'b1, 1'b0, IN_BITS'($urandom));
        step(1'b1, 1'b0, 4'h5);
`ifdef VIDCAP_TEMPORAL_EN
        chk("temporal_x1y2", int'(vif.vramdata), 1);
`else
        chk("temporal_x1y2", int'(vif.vramdata), 2);
`endif
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);

        // full frame with random modes and gaps
        wr_cnt = 0;
        done_cnt = 0;
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);
        for (int l = 0; l < MAX_Y; l++) line_px(MAX_X, 1 + int'($urandom % 3), 1'b1);
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);
        chk("frame_writes", wr_cnt, MAX_X * MAX_Y);
        chk("frame_last_addr", last_addr, 16'h8F9F);
        chk("frame_done_count", done_cnt, 1);

        // x overflow and clear priority
        wr_cnt = 0;
        line_px(170, 0, 1'b1);
        chk("ovf_line_writes", wr_cnt, MAX_X);
        chk("x_ovf_set", int'(x_ovf), 1);
        step(1'b0, 1'b0, '0);
        err_clr = 1'b1;
        step(1'b0, 1'b0, '0);
        err_clr = 1'b0;
        chk("x_ovf_cleared", int'(x_ovf), 0);
        for (int i = 0; i < 170; i++) begin
            err_clr = (i >= 150 && i <= MAX_X);
            step(1'b1, 1'b0, IN_BITS'($urandom));
            if (i == MAX_X) chk("x_ovf_set_wins", int'(x_ovf), 1);
        end
        err_clr = 1'b0;
        step(1'b0, 1'b0, '0);
        err_clr = 1'b1;
        step(1'b0, 1'b0, '0);
        err_clr = 1'b0;

        // y overflow with short lines
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);
        for (int l = 0; l < MAX_Y + 2; l++) line_px(2, 1, 1'b1);
        chk("y_ovf_set", int'(y_ovf), 1);
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);

        // reset in the middle of a line
        line_px(50, 0, 1'b1);
        rst = 1'b1;
        step(1'b1, 1'b0, IN_BITS'($urandom));
        chk("rst_we", int'(vif.vramwe), 0);
        chk("rst_addr", int'(vif.vramaddr), 0);
        chk("rst_data", int'(vif.vramdata), 0);
        chk("rst_flags", int'({x_ovf, y_ovf, frame_done}), 0);
        rst = 1'b0;
        wr_cnt = 0;
        line_px(5, 2, 1'b0);
        chk("post_rst_no_write", wr_cnt, 0);
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, IN_BITS'($urandom));
        chk("post_rst_first_we", int'(vif.vramwe), 1);
        chk("post_rst_first_addr", int'(vif.vramaddr), 0);

        // random traffic: lines, vsyncs (some with de), clears and resets
        for (int k = 0; k < 160; k++) begin
            int r;
            r = int'($urandom % 20);
            err_clr = ($urandom % 8 == 0);
            if (r < 3) begin
                step(1'b0, 1'b1, '0);
            end else if (r == 3) begin
                step(1'b1, 1'b1, IN_BITS'($urandom));
            end else if (r == 4) begin
                rst = 1'b1;
                step(1'($urandom), 1'($urandom), IN_BITS'($urandom));
                rst = 1'b0;
            end else begin
                line_px(int'($urandom_range(1, 175)), int'($urandom_range(1, 3)), 1'b1);
            end
        end
        err_clr = 1'b0;
        step(1'b0, 1'b0, '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
